plot_shadow_fb: RTL and testbench
=================================

// Module: plot_shadow_fb
// PURPOSE
// Receiving end of the pixel-plot stream (plot/x/y/colour) that the game processor drives
// toward the VGA adapter. Taps the same stream and keeps an on-chip 160x120 shadow
// framebuffer. Game logic reads pixel colours back from it for collision and floor
// detection. Provides a pipelined read port and a whole-screen clear engine.
// PARAMETERS
// X_W          8       x coordinate width
// Y_W          7       y coordinate width
// COLOR_W      3       colour width (1 bit per RGB channel)
// WIDTH        160     visible columns; x >= WIDTH is out of range
// HEIGHT       120     visible rows; y >= HEIGHT is out of range
// CLEAR_COLOR  3'b000  colour written by the clear engine
// PORTS
// clk       in   1        system clock (CLOCK_50 domain)
// resetn    in   1        asynchronous active-low reset
// plot      in   1        write strobe; one pixel per cycle it is high
// x         in   X_W      write column
// y         in   Y_W      write row
// colour    in   COLOR_W  write colour
// rd_req    in   1        read request; accepted when rd_req & rd_ready
// rd_x      in   X_W      read column
// rd_y      in   Y_W      read row
// rd_ready  out  1        high when a read can be accepted (= ~busy)
// rd_valid  out  1        one-cycle pulse: rd_color/rd_oob valid
// rd_color  out  COLOR_W  read data
// rd_oob    out  1        read coordinate was out of range
// clear     in   1        pulse: start a full-screen clear
// busy      out  1        high while the clear engine runs
// BEHAVIOUR
// - Memory: simple dual-port RAM, WIDTH*HEIGHT words of COLOR_W bits, synchronous read.
//   addr = y*WIDTH + x, 15 bits unsigned; the multiply must not truncate.
// - Reset values: rd_valid=0, rd_color=0, rd_oob=0, busy=1, rd_ready=0, clear addr=0.
//   Any in-flight read is dropped.
// - FSM states:
//   - CLEAR (entered on reset and from IDLE on clear=1): write CLEAR_COLOR at addr,
//     addr++ each cycle. After writing addr WIDTH*HEIGHT-1, go to IDLE.
//     busy is high for exactly WIDTH*HEIGHT cycles.
//   - IDLE: busy=0, plot and reads serviced.
//   - clear=1 while in CLEAR is ignored; the sweep does not restart.
// - Writes: in IDLE, plot=1 with x<WIDTH and y<HEIGHT writes colour the same cycle.
//   Out-of-range plots are dropped with no aliasing. plot is ignored in CLEAR.
// - Reads:
//   - Accepted at cycle N; rd_valid pulses at N+2 (stage 1 registers the address and
//     range check, stage 2 is the RAM output). Fully pipelined: one read per cycle.
//   - Out-of-range read: no RAM access effect; rd_color=CLEAR_COLOR, rd_oob=1 at N+2.
//   - Reads accepted before entering CLEAR still complete normally at N+2.
// - Read-after-write forwarding: if an in-range plot to the same address occurs at N or
//   N+1, rd_color returns that written colour; the latest write (N+1 over N) wins.
//   Writes at N+2 or later are not visible to the read.
// - A clear-engine write to an address with a read in flight is forwarded the same way.
// - rd_color holds its last value when rd_valid=0; rd_oob is 0 for in-range reads.
// - Asserting resetn low mid-CLEAR or mid-read aborts everything. On release, CLEAR
//   restarts from addr 0.
// TESTING
// 1. Release reset -> busy=1 for exactly 19200 cycles, then 0. Read (0,0) and (159,119)
//    -> rd_color=000, rd_oob=0, rd_valid two cycles after acceptance.
// 2. plot (10,20,101) at cycle N; rd_req (10,20) at N+3 -> rd_valid at N+5,
//    rd_color=101. Back-to-back reads (10,20),(11,20) -> valids on consecutive cycles.
// 3. Read (5,5) at N with plot (5,5,110) at N -> 110. Repeat with plot at N+1 -> 110.
//    Plots at N=011 and N+1=111 -> 111. Plot at N+2 -> old colour returned.
// 4. plot x=160,y=0,colour=111 -> address 160 (pixel (0,1)) still reads 000.
//    rd_req (0,120) -> rd_valid, rd_oob=1, rd_color=000.
// 5. After filling pixels, pulse clear -> busy 19200 cycles; plot and rd_req ignored
//    (rd_ready=0); clear re-pulsed mid-sweep does not extend busy. Afterwards all
//    sampled pixels read 000.
// 6. Assert resetn low when the sweep is at address 5000 with a read in flight ->
//    rd_valid never pulses; after release busy lasts a full 19200 cycles.

Source files
------------

// File: rtl/plot_shadow_fb.sv
// Shadow framebuffer tapped off the pixel-plot stream.
// Pipelined read-back port plus full-screen clear engine.
module plot_shadow_fb #(
  parameter int                  X_W         = 8,
  parameter int                  Y_W         = 7,
  parameter int                  COLOR_W     = 3,
  parameter int                  WIDTH       = 160,
  parameter int                  HEIGHT      = 120,
  parameter logic [COLOR_W-1:0]  CLEAR_COLOR = '0
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               plot,
  input  logic [X_W-1:0]     x,
  input  logic [Y_W-1:0]     y,
  input  logic [COLOR_W-1:0] colour,
  input  logic               rd_req,
  input  logic [X_W-1:0]     rd_x,
  input  logic [Y_W-1:0]     rd_y,
  output logic               rd_ready,
  output logic               rd_valid,
  output logic [COLOR_W-1:0] rd_color,
  output logic               rd_oob,
  input  logic               clear,
  output logic               busy
);

  localparam int DEPTH  = WIDTH * HEIGHT;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_e;

  // Row-major address; operands widened first so y*WIDTH cannot truncate.
  function automatic logic [ADDR_W-1:0] to_addr(
    input logic [X_W-1:0] cx,
    input logic [Y_W-1:0] cy
  );
    return ADDR_W'(cy) * ADDR_W'(WIDTH) + ADDR_W'(cx);
  endfunction

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;

  logic                wr_in;
  logic                rd_in;
  logic [ADDR_W-1:0]   wr_addr;
  logic [ADDR_W-1:0]   rd_addr;
  logic                rd_acc;

  logic                we;
  logic [ADDR_W-1:0]   waddr;
  logic [COLOR_W-1:0]  wdata;

  logic                s1_v_q;
  logic                s1_oob_q;
  logic [ADDR_W-1:0]   s1_addr_q;

  logic                fwd;
  logic                s2_v_q;
  logic                s2_oob_q;
  logic                s2_fwd_q;
  logic [COLOR_W-1:0]  s2_fwd_c_q;
  logic [COLOR_W-1:0]  hold_q;
  logic [COLOR_W-1:0]  ram_q;
  logic [COLOR_W-1:0]  sel;

  logic [COLOR_W-1:0]  mem [DEPTH];

  assign wr_in   = (int'(x) < WIDTH) && (int'(y) < HEIGHT);
  assign rd_in   = (int'(rd_x) < WIDTH) && (int'(rd_y) < HEIGHT);
  assign wr_addr = to_addr(x, y);
  assign rd_addr = to_addr(rd_x, rd_y);

  assign busy     = (state_q == S_CLEAR);
  assign rd_ready = ~busy;
  assign rd_acc   = rd_req & rd_ready;

  // State and clear-sweep address registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_CLEAR;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // Next state and the single RAM write port (sweep or plot).
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    we         = 1'b0;
    waddr      = wr_addr;
    wdata      = colour;
    case (state_q)
      S_CLEAR: begin
        we    = 1'b1;
        waddr = clr_addr_q;
        wdata = CLEAR_COLOR;
        if (clr_addr_q == LAST) begin
          state_d    = S_IDLE;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      S_IDLE: begin
        we = plot & wr_in;
        if (clear) begin
          state_d = S_CLEAR;
        end
      end
      default: begin
        state_d = S_CLEAR;
      end
    endcase
  end

  // Read stage 1: capture address and range check.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_v_q    <= 1'b0;
      s1_oob_q  <= 1'b0;
      s1_addr_q <= '0;
    end else begin
      s1_v_q   <= rd_acc;
      s1_oob_q <= ~rd_in;
      if (rd_acc && rd_in) begin
        s1_addr_q <= rd_addr;
      end
    end
  end

  // Dual-port RAM: one write, one synchronous read (old data on collision).
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    ram_q <= mem[s1_addr_q];
  end

  // A write landing the same cycle as the RAM read is bypassed.
  assign fwd = we & s1_v_q & ~s1_oob_q & (waddr == s1_addr_q);

  // Read stage 2: qualifiers for the RAM output.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s2_v_q     <= 1'b0;
      s2_oob_q   <= 1'b0;
      s2_fwd_q   <= 1'b0;
      s2_fwd_c_q <= '0;
    end else begin
      s2_v_q     <= s1_v_q;
      s2_oob_q   <= s1_oob_q;
      s2_fwd_q   <= fwd;
      s2_fwd_c_q <= wdata;
    end
  end

  assign sel = s2_oob_q ? CLEAR_COLOR :
               s2_fwd_q ? s2_fwd_c_q  : ram_q;

  // Keep the last returned colour visible between reads.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_q <= '0;
    end else if (s2_v_q) begin
      hold_q <= sel;
    end
  end

  assign rd_valid = s2_v_q;
  assign rd_oob   = s2_v_q & s2_oob_q;
  assign rd_color = s2_v_q ? sel : hold_q;

endmodule

// File: tb/tb_plot_shadow_fb.sv
// Randomised bench for plot_shadow_fb against a
// pixel-array reference model.
module tb_plot_shadow_fb;

  localparam int W = 160;
  localparam int H = 120;
  localparam int D = W * H;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       plot = 1'b0;
  logic [7:0] x = '0;
  logic [6:0] y = '0;
  logic [2:0] colour = '0;
  logic       rd_req = 1'b0;
  logic [7:0] rd_x = '0;
  logic [6:0] rd_y = '0;
  logic       rd_ready;
  logic       rd_valid;
  logic [2:0] rd_color;
  logic       rd_oob;
  logic       clear = 1'b0;
  logic       busy;

  plot_shadow_fb dut (
    .clk      (clk),
    .resetn   (resetn),
    .plot     (plot),
    .x        (x),
    .y        (y),
    .colour   (colour),
    .rd_req   (rd_req),
    .rd_x     (rd_x),
    .rd_y     (rd_y),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_color (rd_color),
    .rd_oob   (rd_oob),
    .clear    (clear),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  logic [2:0] m_mem [D];
  bit         m_busy;
  int         m_sweep;
  bit         pend_v;
  bit         pend_oob;
  int         pend_addr;
  logic [2:0] last;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive, advance the model, compare.
  task automatic cyc(input logic p, input logic [7:0] px,
                     input logic [6:0] py, input logic [2:0] pc,
                     input logic rq, input logic [7:0] qx,
                     input logic [6:0] qy, input logic cl);
    bit acc;
    bit a_oob;
    int a_addr;
    logic [2:0] e;
    plot = p; x = px; y = py; colour = pc;
    rd_req = rq; rd_x = qx; rd_y = qy; clear = cl;
    check("busy", busy, m_busy);
    check("rd_ready", rd_ready, !m_busy);
    acc    = rq && !m_busy;
    a_oob  = (int'(qx) >= W) || (int'(qy) >= H);
    a_addr = int'(qy) * W + int'(qx);
    @(posedge clk);
    #1;
    if (m_busy) begin
      m_mem[m_sweep] = 3'b000;
      m_sweep++;
      if (m_sweep == D) m_busy = 0;
    end else begin
      if (p && int'(px) < W && int'(py) < H)
        m_mem[int'(py) * W + int'(px)] = pc;
      if (cl) begin
        m_busy  = 1;
        m_sweep = 0;
      end
    end
    check("rd_valid", rd_valid, pend_v);
    if (pend_v) begin
      e = pend_oob ? 3'b000 : m_mem[pend_addr];
      check("rd_color", rd_color, e);
      check("rd_oob", rd_oob, pend_oob);
      last = e;
    end else begin
      check("rd_hold", rd_color, last);
    end
    pend_v    = acc;
    pend_oob  = a_oob;
    pend_addr = a_addr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rd(input logic [7:0] qx, input logic [6:0] qy);
    cyc(0, 0, 0, 0, 1, qx, qy, 0);
  endtask

  task automatic wr(input logic [7:0] px, input logic [6:0] py,
                    input logic [2:0] pc);
    cyc(1, px, py, pc, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input int hold);
    resetn = 1'b0;
    plot = 0; rd_req = 0; clear = 0;
    repeat (hold) @(posedge clk);
    #1;
    check("rst_busy", busy, 1);
    check("rst_ready", rd_ready, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_color", rd_color, 0);
    check("rst_oob", rd_oob, 0);
    resetn   = 1'b1;
    m_busy   = 1;
    m_sweep  = 0;
    pend_v   = 0;
    last     = 3'b000;
  endtask

  task automatic rand_cyc(input bit cl);
    logic [7:0] px, qx;
    logic [6:0] py, qy;
    bit hot;
    hot = $urandom_range(0, 1) == 1;
    px  = hot ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 175));
    py  = hot ? 7'($urandom_range(0, 3)) : 7'($urandom_range(0, 127));
    hot = $urandom_range(0, 1) == 1;
    qx  = hot ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 175));
    qy  = hot ? 7'($urandom_range(0, 3)) : 7'($urandom_range(0, 127));
    cyc(1'($urandom_range(0, 1)), px, py, 3'($urandom),
        1'($urandom_range(0, 1)), qx, qy, cl);
  endtask

  task automatic wait_idle(input bit junk, input int reclr);
    int n = 0;
    while (busy && n < 20000) begin
      if (junk) rand_cyc(n == reclr);
      else idle(1);
      n++;
    end
    check("busy_len", n, D);
  endtask

  initial begin
    for (int i = 0; i < D; i++) m_mem[i] = 3'b000;
    pend_v = 0;
    last   = 3'b000;

    do_reset(3);
    idle(5000);
    do_reset(2);
    wait_idle(0, -1);

    rd(0, 0);
    rd(159, 119);
    idle(3);

    wr(10, 20, 3'b101);
    idle(2);
    rd(10, 20);
    idle(2);
    rd(10, 20);
    rd(11, 20);
    idle(3);

    wr(5, 5, 3'b001);
    idle(2);
    cyc(1, 5, 5, 3'b110, 1, 5, 5, 0);
    idle(3);
    wr(5, 5, 3'b001);
    idle(2);
    rd(5, 5);
    wr(5, 5, 3'b110);
    idle(3);
    cyc(1, 5, 5, 3'b011, 1, 5, 5, 0);
    wr(5, 5, 3'b111);
    idle(3);
    wr(5, 5, 3'b001);
    idle(2);
    rd(5, 5);
    idle(1);
    wr(5, 5, 3'b100);
    idle(3);

    wr(160, 0, 3'b111);
    idle(1);
    rd(0, 1);
    rd(0, 120);
    rd(200, 127);
    idle(3);

    for (int i = 0; i < 3000; i++) rand_cyc(0);
    idle(2);

    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    wait_idle(1, 7000);
    for (int i = 0; i < 200; i++) rd(8'(i % 4), 7'(i / 50));
    idle(3);

    for (int i = 0; i < 500; i++) rand_cyc(0);
    rd(3, 3);
    do_reset(2);
    wait_idle(0, -1);
    for (int i = 0; i < 1000; i++) rand_cyc(0);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
